// File: rtl/ha1588_axi_master_if.sv
// Command/response and AXI4-Lite register bus bundle for the ha1588 AXI master bridge.
interface ha1588_axi_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Local command/response side
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_wr;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [STRB_WIDTH-1:0]   cmd_wstrb;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic [1:0]              rsp_resp;
    logic                    rsp_timeout;

    // AXI4-Lite register bus
    logic [ADDR_WIDTH-1:0]   M_AXI_REG_AWADDR;
    logic [2:0]              M_AXI_REG_AWPROT;
    logic                    M_AXI_REG_AWVALID;
    logic                    M_AXI_REG_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_REG_WDATA;
    logic [STRB_WIDTH-1:0]   M_AXI_REG_WSTRB;
    logic                    M_AXI_REG_WVALID;
    logic                    M_AXI_REG_WREADY;
    logic [1:0]              M_AXI_REG_BRESP;
    logic                    M_AXI_REG_BVALID;
    logic                    M_AXI_REG_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_REG_ARADDR;
    logic [2:0]              M_AXI_REG_ARPROT;
    logic                    M_AXI_REG_ARVALID;
    logic                    M_AXI_REG_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_REG_RDATA;
    logic [1:0]              M_AXI_REG_RRESP;
    logic                    M_AXI_REG_RVALID;
    logic                    M_AXI_REG_RREADY;

    // Bridge view: accepts commands, masters the AXI bus
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output M_AXI_REG_AWADDR, M_AXI_REG_AWPROT, M_AXI_REG_AWVALID,
        input  M_AXI_REG_AWREADY,
        output M_AXI_REG_WDATA, M_AXI_REG_WSTRB, M_AXI_REG_WVALID,
        input  M_AXI_REG_WREADY,
        input  M_AXI_REG_BRESP, M_AXI_REG_BVALID,
        output M_AXI_REG_BREADY,
        output M_AXI_REG_ARADDR, M_AXI_REG_ARPROT, M_AXI_REG_ARVALID,
        input  M_AXI_REG_ARREADY,
        input  M_AXI_REG_RDATA, M_AXI_REG_RRESP, M_AXI_REG_RVALID,
        output M_AXI_REG_RREADY
    );

    // Environment view: issues commands, acts as the AXI register slave
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  M_AXI_REG_AWADDR, M_AXI_REG_AWPROT, M_AXI_REG_AWVALID,
        output M_AXI_REG_AWREADY,
        input  M_AXI_REG_WDATA, M_AXI_REG_WSTRB, M_AXI_REG_WVALID,
        output M_AXI_REG_WREADY,
        output M_AXI_REG_BRESP, M_AXI_REG_BVALID,
        input  M_AXI_REG_BREADY,
        input  M_AXI_REG_ARADDR, M_AXI_REG_ARPROT, M_AXI_REG_ARVALID,
        output M_AXI_REG_ARREADY,
        output M_AXI_REG_RDATA, M_AXI_REG_RRESP, M_AXI_REG_RVALID,
        input  M_AXI_REG_RREADY
    );

endinterface

// File: rtl/ha1588_axi_master.sv
// Single-outstanding AXI4-Lite master: turns local register commands into
// AXI4-Lite reads/writes with a per-transaction response watchdog.
// Only a 32-bit data path is supported.
module ha1588_axi_master #(
    parameter int unsigned C_M_AXI_REG_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_REG_DATA_WIDTH = 32,
    parameter int unsigned C_TIMEOUT_CYCLES       = 1024
) (
    input  logic                M_AXI_REG_ACLK,
    input  logic                M_AXI_REG_ARESETN,
    ha1588_axi_master_if.master bus
);

    localparam int unsigned AW    = C_M_AXI_REG_ADDR_WIDTH;
    localparam int unsigned DW    = C_M_AXI_REG_DATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned CNT_W = $clog2(C_TIMEOUT_CYCLES + 1) + 1;
    // Counter value on the last cycle a transaction may still complete
    localparam int unsigned LIMIT = (C_TIMEOUT_CYCLES == 0) ? 0 : C_TIMEOUT_CYCLES - 1;
    localparam bit          WDOG_EN = (C_TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic            bready_q, bready_d;
    logic            rready_q, rready_d;

    logic             expire;
    logic             aw_left;
    logic             w_left;
    logic             finish_ok;
    logic             finish_to;
    logic [CNT_W-1:0] cnt_inc;

    // Watchdog expiry and saturating increment
    always_comb begin
        expire  = WDOG_EN && (cnt_q >= CNT_W'(LIMIT));
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        aw_left       = awvalid_q & ~bus.M_AXI_REG_AWREADY;
        w_left        = wvalid_q & ~bus.M_AXI_REG_WREADY;
        finish_ok     = 1'b0;
        finish_to     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                cnt_d       = '0;
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    wstrb_d     = bus.cmd_wstrb;
                    if (bus.cmd_wr) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                cnt_d     = cnt_inc;
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (expire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    finish_to = 1'b1;
                end
            end
            WR_RESP: begin
                cnt_d = cnt_inc;
                if (bus.M_AXI_REG_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = bus.M_AXI_REG_BRESP;
                    rsp_rdata_d = '0;
                    finish_ok   = 1'b1;
                end else if (expire) begin
                    bready_d  = 1'b0;
                    finish_to = 1'b1;
                end
            end
            RD_REQ: begin
                cnt_d = cnt_inc;
                if (bus.M_AXI_REG_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end else if (expire) begin
                    arvalid_d = 1'b0;
                    finish_to = 1'b1;
                end
            end
            RD_RESP: begin
                cnt_d = cnt_inc;
                if (bus.M_AXI_REG_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = bus.M_AXI_REG_RDATA;
                    rsp_resp_d  = bus.M_AXI_REG_RRESP;
                    finish_ok   = 1'b1;
                end else if (expire) begin
                    rready_d  = 1'b0;
                    finish_to = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common completion: one-cycle response pulse and re-open the command port
        if (finish_ok) begin
            state_d       = DONE;
            cmd_ready_d   = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
        end
        if (finish_to) begin
            state_d       = DONE;
            cmd_ready_d   = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge M_AXI_REG_ACLK) begin
        if (!M_AXI_REG_ARESETN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
        end
    end

    // Drive the bundle from the registers
    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rdata         = rsp_rdata_q;
    assign bus.rsp_resp          = rsp_resp_q;
    assign bus.rsp_timeout       = rsp_timeout_q;
    assign bus.M_AXI_REG_AWADDR  = addr_q;
    assign bus.M_AXI_REG_AWPROT  = 3'b000;
    assign bus.M_AXI_REG_AWVALID = awvalid_q;
    assign bus.M_AXI_REG_WDATA   = wdata_q;
    assign bus.M_AXI_REG_WSTRB   = wstrb_q;
    assign bus.M_AXI_REG_WVALID  = wvalid_q;
    assign bus.M_AXI_REG_BREADY  = bready_q;
    assign bus.M_AXI_REG_ARADDR  = addr_q;
    assign bus.M_AXI_REG_ARPROT  = 3'b000;
    assign bus.M_AXI_REG_ARVALID = arvalid_q;
    assign bus.M_AXI_REG_RREADY  = rready_q;

endmodule

// File: tb/tb_ha1588_axi_master.sv
// Bench for ha1588_axi_master: table of commands against a delay-programmable
// AXI4-Lite slave model, responses checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_ha1588_axi_master;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 8;
    localparam int          NEVER = 255;
    localparam int          NV  = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ha1588_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ha1588_axi_master #(
        .C_M_AXI_REG_ADDR_WIDTH(AW),
        .C_M_AXI_REG_DATA_WIDTH(DW),
        .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_REG_ACLK(clk),
        .M_AXI_REG_ARESETN(rstn),
        .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        b2b;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
        int          exp_lat;
        int          exp_arv;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          lat;
        int          acc_cyc;
        int          arv;
    } exp_t;

    vec_t vecs [NV];
    vec_t cur;
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   arv_run = 0;

    // Slave model state
    bit aw_got, w_got, ar_got;
    bit aw_pend, w_pend, ar_pend, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit prev_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int awd, input int wd, input int bd,
                                input int ard, input int rd, input logic [1:0] bresp,
                                input logic [31:0] rdata, input logic [1:0] rresp, input logic b2b,
                                input logic [31:0] er, input logic [1:0] eresp, input logic eto,
                                input int lat, input int arv);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = strb;
        v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
        v.bresp = bresp; v.rdata = rdata; v.rresp = rresp; v.b2b = b2b;
        v.exp_rdata = er; v.exp_resp = eresp; v.exp_to = eto; v.exp_lat = lat; v.exp_arv = arv;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // AXI4-Lite slave model; handshakes seen here fire on the following rising edge
    always @(negedge clk) begin
        if (!rstn) begin
            bus.M_AXI_REG_AWREADY = 1'b0;
            bus.M_AXI_REG_WREADY  = 1'b0;
            bus.M_AXI_REG_BVALID  = 1'b0;
            bus.M_AXI_REG_BRESP   = 2'b00;
            bus.M_AXI_REG_ARREADY = 1'b0;
            bus.M_AXI_REG_RVALID  = 1'b0;
            bus.M_AXI_REG_RDATA   = '0;
            bus.M_AXI_REG_RRESP   = 2'b00;
            {aw_got, w_got, ar_got} = '0;
            {aw_pend, w_pend, ar_pend, b_pend, r_pend} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            if (aw_pend) begin
                aw_got = 1'b1;
                chk("awvalid_drop", 32'(bus.M_AXI_REG_AWVALID), 32'd0);
            end
            if (w_pend) begin
                w_got = 1'b1;
                chk("wvalid_drop", 32'(bus.M_AXI_REG_WVALID), 32'd0);
            end
            if (ar_pend) begin
                ar_got = 1'b1;
                chk("arvalid_drop", 32'(bus.M_AXI_REG_ARVALID), 32'd0);
            end
            if (b_pend) begin
                bus.M_AXI_REG_BVALID = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
            end
            if (r_pend) begin
                bus.M_AXI_REG_RVALID = 1'b0;
                ar_got = 1'b0; r_cnt = 0;
            end

            if (bus.M_AXI_REG_AWVALID && !aw_got) begin
                if (aw_cnt >= cur.aw_dly) bus.M_AXI_REG_AWREADY = 1'b1;
                else begin bus.M_AXI_REG_AWREADY = 1'b0; aw_cnt++; end
            end else begin
                bus.M_AXI_REG_AWREADY = 1'b0; aw_cnt = 0;
            end
            if (bus.M_AXI_REG_WVALID && !w_got) begin
                if (w_cnt >= cur.w_dly) bus.M_AXI_REG_WREADY = 1'b1;
                else begin bus.M_AXI_REG_WREADY = 1'b0; w_cnt++; end
            end else begin
                bus.M_AXI_REG_WREADY = 1'b0; w_cnt = 0;
            end
            if (bus.M_AXI_REG_ARVALID && !ar_got) begin
                if (cur.ar_dly != NEVER && ar_cnt >= cur.ar_dly) bus.M_AXI_REG_ARREADY = 1'b1;
                else begin bus.M_AXI_REG_ARREADY = 1'b0; ar_cnt++; end
            end else begin
                bus.M_AXI_REG_ARREADY = 1'b0; ar_cnt = 0;
            end
            if (aw_got && w_got && !bus.M_AXI_REG_BVALID) begin
                if (b_cnt >= cur.b_dly) begin
                    bus.M_AXI_REG_BVALID = 1'b1;
                    bus.M_AXI_REG_BRESP  = cur.bresp;
                end else b_cnt++;
            end
            if (ar_got && !bus.M_AXI_REG_RVALID) begin
                if (r_cnt >= cur.r_dly) begin
                    bus.M_AXI_REG_RVALID = 1'b1;
                    bus.M_AXI_REG_RDATA  = cur.rdata;
                    bus.M_AXI_REG_RRESP  = cur.rresp;
                end else r_cnt++;
            end

            aw_pend = bus.M_AXI_REG_AWVALID && bus.M_AXI_REG_AWREADY;
            w_pend  = bus.M_AXI_REG_WVALID && bus.M_AXI_REG_WREADY;
            ar_pend = bus.M_AXI_REG_ARVALID && bus.M_AXI_REG_ARREADY;
            b_pend  = bus.M_AXI_REG_BVALID && bus.M_AXI_REG_BREADY;
            r_pend  = bus.M_AXI_REG_RVALID && bus.M_AXI_REG_RREADY;
            if (aw_pend) begin
                chk("awaddr", bus.M_AXI_REG_AWADDR, cur.addr);
                chk("awprot", 32'(bus.M_AXI_REG_AWPROT), 32'd0);
            end
            if (w_pend) begin
                chk("wdata", bus.M_AXI_REG_WDATA, cur.wdata);
                chk("wstrb", 32'(bus.M_AXI_REG_WSTRB), 32'(cur.wstrb));
            end
            if (ar_pend) begin
                chk("araddr", bus.M_AXI_REG_ARADDR, cur.addr);
                chk("arprot", 32'(bus.M_AXI_REG_ARPROT), 32'd0);
            end
            if (bus.M_AXI_REG_BREADY) chk("bready_after_aw_w", 32'(aw_got && w_got), 32'd1);
            if (bus.M_AXI_REG_RREADY) chk("rready_after_ar", 32'(ar_got), 32'd1);
            if (bus.M_AXI_REG_ARVALID) arv_run++;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (bus.rsp_valid) begin
                chk("rsp_pulse_width", 32'(prev_rsp), 32'd0);
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(bus.rsp_resp), 32'(e.resp));
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
                    chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    if (e.arv != 0) chk("arvalid_cycles", 32'(arv_run), 32'(e.arv));
                end
            end
            prev_rsp = bus.rsp_valid;
        end else begin
            prev_rsp = 1'b0;
        end
    end

    // Present one command at a negedge and hold it until accepted
    task automatic issue(input vec_t v, input bit track);
        int w;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_wstrb = v.wstrb;
        w = 0;
        while (!bus.cmd_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_accept_wait", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (v.b2b) chk("b2b_accept_in_done", 32'(bus.rsp_valid), 32'd1);
        cur = v;
        arv_run = 0;
        if (track) sb.push_back('{rdata: v.exp_rdata, resp: v.exp_resp, to: v.exp_to,
                                  lat: v.exp_lat, acc_cyc: cyc, arv: v.exp_arv});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            chk("rsp_wait", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int w;
        vec_t rv;
        // wr addr wdata strb | aw w b ar r | bresp rdata rresp b2b | exp_rdata exp_resp exp_to lat arv
        vecs[0]  = mk(1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 3, 0);
        vecs[1]  = mk(1, 32'h20, 32'hDEAD_BEEF, 4'h3, 0, 3, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 6, 0);
        vecs[2]  = mk(0, 32'h04, 0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 2'b00, 0,
                      32'h1234_5678, 2'b00, 0, 5, 0);
        vecs[3]  = mk(0, 32'h08, 0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 2'b00, 1,
                      32'hCAFE_F00D, 2'b00, 0, 3, 0);
        vecs[4]  = mk(1, 32'h30, 32'h1, 4'h1, 0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 0, 0, 2'b10, 0, 3, 0);
        vecs[5]  = mk(1, 32'h34, 32'h0BAD_F00D, 4'hC, 2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 5, 0);
        vecs[6]  = mk(0, 32'h40, 0, 4'h0, 0, 0, 0, NEVER, 0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 1, 9, 8);
        vecs[7]  = mk(0, 32'h44, 0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 32'h0000_55AA, 2'b00, 0,
                      32'h0000_55AA, 2'b00, 0, 4, 0);
        vecs[8]  = mk(0, 32'h48, 0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_0000, 2'b11, 0,
                      32'hFFFF_0000, 2'b11, 0, 3, 0);
        vecs[9]  = mk(1, 32'h50, 32'h1111_2222, 4'hF, 7, 7, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 2'b01, 0, 10, 0);
        vecs[10] = mk(1, 32'h54, 32'h3333_4444, 4'hF, 8, 8, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 1, 9, 0);
        vecs[11] = mk(1, 32'h58, 32'h5555_AAAA, 4'hF, 0, 0, 2, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 5, 0);
        cur = vecs[0];

        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_rsp_resp", 32'(bus.rsp_resp), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_valids", 32'({bus.M_AXI_REG_AWVALID, bus.M_AXI_REG_WVALID, bus.M_AXI_REG_ARVALID}), 32'd0);
        chk("rst_readies", 32'({bus.M_AXI_REG_BREADY, bus.M_AXI_REG_RREADY}), 32'd0);
        chk("rst_awaddr", bus.M_AXI_REG_AWADDR, 32'd0);
        chk("rst_wdata", bus.M_AXI_REG_WDATA, 32'd0);
        chk("rst_araddr", bus.M_AXI_REG_ARADDR, 32'd0);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], 1'b1);
            if (!(i + 1 < NV && vecs[i + 1].b2b)) begin
                drain();
                @(negedge clk);
            end
        end

        // Reset while the write waits for its response: nothing may come back
        rv = mk(1, 32'h60, 32'h7777_8888, 4'hF, 0, 0, 6, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        issue(rv, 1'b0);
        w = 0;
        while (!bus.M_AXI_REG_BREADY && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bready_wait", 32'(bus.M_AXI_REG_BREADY), 32'd1);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("midrst_bready", 32'(bus.M_AXI_REG_BREADY), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        repeat (10) @(negedge clk);

        // Normal write after the aborted one
        issue(vecs[0], 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
